// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU codes, opcodes, condition codes.
// No logic, no latency; no flow control.
// No backpressure.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_ALUWB2, S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_UMULL = 3'b101;
  localparam logic [2:0] ALU_SMULL = 3'b110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [3:0] CMD_AND   = 4'b0000;
  localparam logic [3:0] CMD_SUB   = 4'b0010;
  localparam logic [3:0] CMD_ADD   = 4'b0100;
  localparam logic [3:0] CMD_CMP   = 4'b1010;
  localparam logic [3:0] CMD_ORR   = 4'b1100;
  localparam logic [3:0] CMD_MUL   = 4'b0000;
  localparam logic [3:0] CMD_UMULL = 4'b0100;
  localparam logic [3:0] CMD_SMULL = 4'b0110;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register, condition evaluator and the per-instruction CondEx flop.
// Flags/CondEx update one cycle after their load strobes; evaluation reads the registered flags.
// No backpressure.
module arm_cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic       condex_ld,
  input  logic       nz_we,
  input  logic       cv_we,
  output logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;
  logic pass;

  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = ~(n ^ v);
      COND_LT: pass = n ^ v;
      COND_GT: pass = ~z & ~(n ^ v);
      COND_LE: pass = z | (n ^ v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= 4'b0000;
      condex <= 1'b0;
    end else begin
      if (condex_ld) condex <= pass;
      if (nz_we) flags[3:2] <= aluflags[3:2];
      if (cv_we) flags[1:0] <= aluflags[1:0];
    end
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM; B 3, STR/DP 4, LDR 5 cycles (UMULL/SMULL 5 with LONG_MUL_EN).
// Moore outputs from state plus CondEx; no backpressure, one instruction in flight.
module arm_mc_controller
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] MulBits,
  input  logic [3:0] ALUFlags,
  output logic [2:0] ALUControl,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags
);

  state_t     state;
  logic       condex;
  logic [3:0] cmd;
  logic       is_mul, is_cmp, is_exec, rd_pc;
  logic [2:0] dp_ctrl;
  logic       nz_we, cv_we;

  assign cmd     = Funct[4:1];
  assign is_mul  = (Op == OP_DP) && !Funct[5] && (MulBits == 4'b1001);
  assign is_cmp  = (cmd == CMD_CMP);
  assign is_exec = (state == S_EXECR) || (state == S_EXECI);
  assign rd_pc   = (Rd == 4'b1111);

`ifdef LONG_MUL_EN
  logic is_long;
  assign is_long = is_mul && ((cmd == CMD_UMULL) || (cmd == CMD_SMULL));
`endif

  always_comb begin
    dp_ctrl = ALU_ADD;
    if (is_mul && (cmd == CMD_MUL)) begin
      dp_ctrl = ALU_MUL;
    end else if (is_mul && ((cmd == CMD_UMULL) || (cmd == CMD_SMULL))) begin
`ifdef LONG_MUL_EN
      dp_ctrl = (cmd == CMD_UMULL) ? ALU_UMULL : ALU_SMULL;
`else
      dp_ctrl = ALU_MUL;
`endif
    end else begin
      case (cmd)
        CMD_ADD:          dp_ctrl = ALU_ADD;
        CMD_SUB, CMD_CMP: dp_ctrl = ALU_SUB;
        CMD_AND:          dp_ctrl = ALU_AND;
        CMD_ORR:          dp_ctrl = ALU_OR;
        default:          dp_ctrl = ALU_ADD;
      endcase
    end
  end

  assign ALUControl = is_exec ? dp_ctrl : ALU_ADD;

  // Multiplies keep C and V; only the add/subtract family produces them.
  assign nz_we = is_exec & condex & Funct[0];
  assign cv_we = nz_we & (ALUControl[2:1] == 2'b00);

  arm_cond_unit u_cond (
    .clk       (clk),
    .rst_n     (reset),
    .cond      (Cond),
    .aluflags  (ALUFlags),
    .condex_ld (state == S_DECODE),
    .nz_we     (nz_we),
    .cv_we     (cv_we),
    .flags     (Flags),
    .condex    (condex)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_MEM:  state <= S_MEMADR;
            OP_BR:   state <= S_BRANCH;
            OP_DP:   state <= Funct[5] ? S_EXECI : S_EXECR;
            default: state <= S_FETCH;
          endcase
        end
        S_MEMADR: state <= Funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state <= S_MEMWB;
        S_EXECR,
        S_EXECI:  state <= S_ALUWB;
`ifdef LONG_MUL_EN
        S_ALUWB:  state <= is_long ? S_ALUWB2 : S_FETCH;
`else
        S_ALUWB:  state <= S_FETCH;
`endif
        default:  state <= S_FETCH;
      endcase
    end
  end

  assign ImmSrc = Op;
  assign RegSrc = {Op == OP_MEM, Op == OP_BR};

  always_comb begin
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    case (state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condex;
        PCWrite   = condex & rd_pc;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condex;
      end
      S_EXECI:  ALUSrcB = 2'b01;
      S_ALUWB: begin
        RegWrite = condex & ~is_cmp;
        PCWrite  = condex & rd_pc;
      end
`ifdef LONG_MUL_EN
      S_ALUWB2: begin
        ResultSrc = 2'b11;
        RegWrite  = condex;
      end
`endif
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condex;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench for arm_mc_controller: directed test-plan cases then random instructions
// against a per-instruction cycle model built from the architectural rules.
module tb_arm_mc_controller;

  logic       clk, reset;
  logic [3:0] Cond, Rd, MulBits, ALUFlags, Flags;
  logic [1:0] Op, ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [5:0] Funct;
  logic [2:0] ALUControl;
  logic       PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags;

  typedef struct packed {
    logic       ir, pc, rw, mw;
    logic [2:0] alu;
    logic       rs_chk;
    logic [1:0] rs;
    logic [3:0] fl;
  } cyc_t;

  arm_mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .MulBits(MulBits), .ALUFlags(ALUFlags), .ALUControl(ALUControl),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ARM conditions come in true/false pairs: the low bit inverts the base test.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic bit is_long_mul(input logic [5:0] f, input logic [3:0] mb);
`ifdef LONG_MUL_EN
    return !f[5] && mb == 4'b1001 && (f[4:1] == 4'b0100 || f[4:1] == 4'b0110);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] alu_code(input logic [5:0] f, input logic [3:0] mb);
    logic [3:0] cmd;
    cmd = f[4:1];
    if (!f[5] && mb == 4'b1001 && (cmd == 4'b0000 || cmd == 4'b0100 || cmd == 4'b0110)) begin
      if (cmd == 4'b0000) return 3'b100;
`ifdef LONG_MUL_EN
      return (cmd == 4'b0100) ? 3'b101 : 3'b110;
`else
      return 3'b100;
`endif
    end
    case (cmd)
      4'b0100: return 3'b000;
      4'b0010: return 3'b001;
      4'b0000: return 3'b010;
      4'b1100: return 3'b011;
      4'b1010: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic cyc_t mk(input bit ir, pc, rw, mw, input logic [2:0] alu,
                              input bit rs_chk, input logic [1:0] rs, input logic [3:0] fl);
    cyc_t e;
    e = '{ir: ir, pc: pc, rw: rw, mw: mw, alu: alu, rs_chk: rs_chk, rs: rs, fl: fl};
    return e;
  endfunction

  // Called just after a rising edge with the DUT in FETCH; returns just after the edge that ends the instruction.
  task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd, input logic [3:0] mb,
                           input logic [3:0] af);
    cyc_t q[$];
    cyc_t e;
    bit pass;
    logic [2:0] ctrl;
    logic [3:0] nf;
    Cond = c; Op = op; Funct = f; Rd = rd; MulBits = mb; ALUFlags = af;
    pass = cond_ok(c, mflags);
    q.push_back(mk(1, 1, 0, 0, 3'b000, 1, 2'b10, mflags));
    q.push_back(mk(0, 0, 0, 0, 3'b000, 0, 2'b00, mflags));
    case (op)
      2'b10: q.push_back(mk(0, pass, 0, 0, 3'b000, 1, 2'b10, mflags));
      2'b01: begin
        q.push_back(mk(0, 0, 0, 0, 3'b000, 0, 2'b00, mflags));
        if (f[0]) begin
          q.push_back(mk(0, 0, 0, 0, 3'b000, 0, 2'b00, mflags));
          q.push_back(mk(0, pass && rd == 4'hF, pass, 0, 3'b000, 1, 2'b01, mflags));
        end else begin
          q.push_back(mk(0, 0, 0, pass, 3'b000, 0, 2'b00, mflags));
        end
      end
      2'b00: begin
        ctrl = alu_code(f, mb);
        q.push_back(mk(0, 0, 0, 0, ctrl, 0, 2'b00, mflags));
        nf = mflags;
        if (pass && f[0]) begin
          nf[3:2] = af[3:2];
          if (ctrl == 3'b000 || ctrl == 3'b001) nf[1:0] = af[1:0];
        end
        q.push_back(mk(0, pass && rd == 4'hF, pass && f[4:1] != 4'b1010, 0, 3'b000, 1, 2'b00, nf));
        if (is_long_mul(f, mb)) q.push_back(mk(0, 0, pass, 0, 3'b000, 1, 2'b11, nf));
        mflags = nf;
      end
      default: ;
    endcase
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) @(posedge clk);
      #1;
      e = q[k];
      chk($sformatf("%s c%0d ctl", name, k),
          {21'b0, IRWrite, PCWrite, RegWrite, MemWrite, ALUControl, Flags},
          {21'b0, e.ir, e.pc, e.rw, e.mw, e.alu, e.fl});
      if (e.rs_chk) chk($sformatf("%s c%0d ResultSrc", name, k), {30'b0, ResultSrc}, {30'b0, e.rs});
      if (e.ir) chk($sformatf("%s c%0d AdrSrc", name, k), {31'b0, AdrSrc}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fetch_vec;

  initial begin
    logic [3:0] rc, rrd, rmb, raf;
    logic [1:0] rop;
    logic [5:0] rf;
    reset = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; MulBits = 4'd0; ALUFlags = 4'd0;
    mflags = 4'b0000;
    fetch_vec = {14'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 3'b000, 4'b0000};
    #12;
    chk("reset_state", {14'b0, IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
        ResultSrc, ALUControl, Flags}, fetch_vec);
    chk("reset_known", {31'b0, $isunknown({ImmSrc, RegSrc})}, 32'd0);
    reset = 1'b1;

    run_instr("ANDS",     4'hE, 2'b00, 6'b000001, 4'd1,  4'b0000, 4'b1011);
    run_instr("SUBEQ",    4'h0, 2'b00, 6'b100100, 4'd2,  4'b0000, 4'b1111);
    run_instr("ADDS",     4'hE, 2'b00, 6'b101001, 4'd3,  4'b0000, 4'b0110);
    run_instr("LDR_PC",   4'hE, 2'b01, 6'b011001, 4'hF,  4'b0000, 4'b0000);
    run_instr("SMULL",    4'hE, 2'b00, 6'b001100, 4'd4,  4'b1001, 4'b1111);
    run_instr("UMULLS",   4'hE, 2'b00, 6'b001001, 4'd5,  4'b1001, 4'b1001);
    run_instr("B",        4'hE, 2'b10, 6'b110101, 4'd0,  4'b0000, 4'b0000);
    run_instr("STR",      4'hE, 2'b01, 6'b011000, 4'd6,  4'b0000, 4'b0000);
    run_instr("OP11",     4'hE, 2'b11, 6'b111111, 4'hF,  4'b0000, 4'b1111);
    run_instr("CMP_NV",   4'hF, 2'b00, 6'b110101, 4'd1,  4'b0000, 4'b0101);

    // Asynchronous reset in the middle of an ORRS execute cycle, flags nonzero beforehand.
    Cond = 4'hE; Op = 2'b00; Funct = 6'b111001; Rd = 4'd7; MulBits = 4'd0; ALUFlags = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_exec_alu", {29'b0, ALUControl}, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset_async", {14'b0, IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
        ResultSrc, ALUControl, Flags}, fetch_vec);
    @(posedge clk); #1;
    chk("mid_reset_hold", {14'b0, IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
        ResultSrc, ALUControl, Flags}, fetch_vec);
    #2 reset = 1'b1;
    mflags = 4'b0000;
    run_instr("post_reset", 4'hE, 2'b00, 6'b100101, 4'd8, 4'b0000, 4'b0011);

    for (int n = 0; n < 300; n++) begin
      rc  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      rop = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rf  = 6'($urandom);
      rrd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      rmb = 4'($urandom);
      raf = 4'($urandom);
      if (rop == 2'b00 && !rf[5] && $urandom_range(0, 2) == 0) begin
        rmb = 4'b1001;
        case ($urandom_range(0, 2))
          0: rf[4:1] = 4'b0000;
          1: rf[4:1] = 4'b0100;
          default: rf[4:1] = 4'b0110;
        endcase
      end else begin
        if (rmb == 4'b1001) rmb = 4'b0000;
        if (rop == 2'b00 && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 4))
            0: rf[4:1] = 4'b0100;
            1: rf[4:1] = 4'b0010;
            2: rf[4:1] = 4'b0000;
            3: rf[4:1] = 4'b1100;
            default: rf[4:1] = 4'b1010;
          endcase
        end
      end
      run_instr($sformatf("rnd%0d", n), rc, rop, rf, rrd, rmb, raf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
